// File: rtl/ysyx_040729_mmio_pkg.sv
// rtl/ysyx_040729_mmio_pkg.sv - shared FSM type, size encodings and width defaults for the MMIO master
package ysyx_040729_mmio_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_RD_LATENCY = 1;

  // req_size[1:0] is log2 of the byte count; req_size[SZ_U_BIT] selects zero-extension
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int SZ_U_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic [2:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 3'b000;
      SZ_H:    size_mask = 3'b001;
      SZ_W:    size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_040729_mmio_if.sv
// rtl/ysyx_040729_mmio_if.sv - CPU request/response and responder bus signals of the MMIO master
interface ysyx_040729_mmio_if import ysyx_040729_mmio_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_wen;
  logic [2:0]            req_size;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic                  bus_sel;
  logic                  bus_wen;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [2:0]            bus_size;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    input  req_valid, req_addr, req_wdata, req_wen, req_size,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output bus_sel, bus_wen, bus_addr, bus_wdata, bus_size,
    input  bus_rdata
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_wen, req_size,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  bus_sel, bus_wen, bus_addr, bus_wdata, bus_size,
    output bus_rdata
  );

endinterface

// File: rtl/ysyx_040729_mmio_align_chk.sv
// rtl/ysyx_040729_mmio_align_chk.sv - combinational natural-alignment test of a request address
module ysyx_040729_mmio_align_chk import ysyx_040729_mmio_pkg::*; (
  input  logic [2:0] addr_lo,
  input  logic [1:0] size,
  output logic       misaligned
);

  assign misaligned = |(addr_lo & size_mask(size));

endmodule

// File: rtl/ysyx_040729_mmio_master.sv
// rtl/ysyx_040729_mmio_master.sv - single-outstanding MMIO bus master
// YSYX_040729_MMIO_ALIGN_CHECK_EN: answer misaligned requests with resp_err instead of issuing them
module ysyx_040729_mmio_master import ysyx_040729_mmio_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input logic                 clock,
  input logic                 reset,
  ysyx_040729_mmio_if.master  mmio
);

  localparam logic [2:0] LAST_WAIT = 3'(RD_LATENCY - 1);

  state_t                state_q;
  state_t                state_d;
  logic [2:0]            wait_cnt_q;
  logic                  wait_last;
  logic                  req_ready_c;
  logic                  resp_valid_c;
  logic                  bus_sel_c;
  logic                  accept;
  logic                  go_resp_direct;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wen_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign wait_last = (wait_cnt_q == LAST_WAIT);
  assign accept    = mmio.req_valid && req_ready_c;

`ifdef YSYX_040729_MMIO_ALIGN_CHECK_EN
  logic misaligned;
  logic err_q;

  ysyx_040729_mmio_align_chk u_align_chk (
    .addr_lo    (mmio.req_addr[2:0]),
    .size       (mmio.req_size[1:0]),
    .misaligned (misaligned)
  );

  assign go_resp_direct = misaligned;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end

  assign mmio.resp_err = err_q;
`else
  assign go_resp_direct = 1'b0;
  assign mmio.resp_err  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    bus_sel_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (mmio.req_valid) begin
          state_d = go_resp_direct ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus_sel_c = 1'b1;
        state_d   = wen_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_last) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid_c = 1'b1;
        if (mmio.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturates at LAST_WAIT so the 3-bit counter cannot wrap even with RD_LATENCY = 7
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 3'd0;
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= 3'd0;
    end else if (state_q == ST_WAIT && !wait_last) begin
      wait_cnt_q <= wait_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      size_q  <= 3'd0;
    end else if (accept) begin
      addr_q  <= mmio.req_addr;
      wdata_q <= mmio.req_wdata;
      wen_q   <= mmio.req_wen;
      size_q  <= mmio.req_size;
    end
  end

  // Cleared on acceptance so writes and error responses return zero data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= '0;
    end else if (state_q == ST_WAIT && wait_last) begin
      rdata_q <= mmio.bus_rdata;
    end
  end

  assign mmio.req_ready  = req_ready_c;
  assign mmio.resp_valid = resp_valid_c;
  assign mmio.resp_rdata = rdata_q;
  assign mmio.bus_sel    = bus_sel_c;
  assign mmio.bus_wen    = wen_q;
  assign mmio.bus_addr   = addr_q;
  assign mmio.bus_wdata  = wdata_q;
  assign mmio.bus_size   = size_q;

endmodule
